// File: rtl/airlock_seq_ctrl.sv
// Bathysphere airlock interlock sequencer with internal hold/fill/drain timers.
// Runs arrive/depart cycles, gates door permits, tracks pressure and latches safety faults.
module airlock_seq_ctrl #(
    parameter int CNT_W     = 24,
    parameter int WAIT_CYC  = 250,
    parameter int FILL_CYC  = 100,
    parameter int DRAIN_CYC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       inner_sw,
    input  logic       outer_sw,
    input  logic       occupied,
    input  logic       fault_clr,
    output logic       inner_en,
    output logic       outer_en,
    output logic       filling,
    output logic       draining,
    output logic       waiting,
    output logic       pressure_high,
    output logic       busy,
    output logic       fault,
    output logic [3:0] state_leds
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HOLD    = 4'd1,
        S_FILL    = 4'd2,
        S_DRAIN   = 4'd3,
        S_IN_REL  = 4'd4,
        S_IN_USE  = 4'd5,
        S_OUT_REL = 4'd6,
        S_OUT_USE = 4'd7,
        S_FAULT   = 4'd15
    } state_t;

    localparam logic DIR_ARR = 1'b0;
    localparam logic DIR_DEP = 1'b1;

    // A zero-length phase is treated as one cycle long.
    localparam int WAIT_LAST_I  = (WAIT_CYC  == 0) ? 0 : WAIT_CYC  - 1;
    localparam int FILL_LAST_I  = (FILL_CYC  == 0) ? 0 : FILL_CYC  - 1;
    localparam int DRAIN_LAST_I = (DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1;
    localparam logic [CNT_W-1:0] WAIT_LAST  = WAIT_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] FILL_LAST  = FILL_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DRAIN_LAST = DRAIN_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] timer_reg;
    logic             dir_reg;
    logic             dir_next;
    logic             rec_reg;
    logic             rec_next;
    logic             trip;
    logic             timed_next;

    assign trip = (inner_sw & ~inner_en) | (outer_sw & ~outer_en) | (inner_sw & outer_sw);
    assign timed_next = (state_next == S_HOLD) || (state_next == S_FILL) || (state_next == S_DRAIN);

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        rec_next   = rec_reg;
        case (state_reg)
            S_IDLE: begin
                if (arrive_req) begin
                    state_next = S_HOLD;
                    dir_next   = DIR_ARR;
                end else if (depart_req) begin
                    state_next = S_HOLD;
                    dir_next   = DIR_DEP;
                end
            end
            S_HOLD: begin
                if (timer_reg == WAIT_LAST)
                    state_next = (dir_reg == DIR_ARR) ? S_FILL : S_IN_REL;
            end
            S_FILL: begin
                if (timer_reg == FILL_LAST)
                    state_next = S_OUT_REL;
            end
            S_DRAIN: begin
                if (timer_reg == DRAIN_LAST) begin
                    state_next = (rec_reg || dir_reg == DIR_DEP) ? S_IDLE : S_IN_REL;
                    rec_next   = 1'b0;
                end
            end
            S_IN_REL: begin
                if (inner_sw)
                    state_next = S_IN_USE;
            end
            S_IN_USE: begin
                if (!inner_sw) begin
                    if (dir_reg == DIR_DEP)
                        state_next = S_FILL;
                    else
                        state_next = occupied ? S_IN_REL : S_IDLE;
                end
            end
            S_OUT_REL: begin
                if (outer_sw)
                    state_next = S_OUT_USE;
            end
            S_OUT_USE: begin
                if (!outer_sw)
                    state_next = (dir_reg == DIR_DEP && occupied) ? S_OUT_REL : S_DRAIN;
            end
            S_FAULT: begin
                if (fault_clr && !inner_sw && !outer_sw) begin
                    state_next = pressure_high ? S_DRAIN : S_IDLE;
                    rec_next   = pressure_high;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // A door violation overrides every other transition.
        if (state_reg != S_FAULT && trip) begin
            state_next = S_FAULT;
            dir_next   = dir_reg;
            rec_next   = rec_reg;
        end
    end

    // Outputs are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            dir_reg       <= DIR_ARR;
            rec_reg       <= 1'b0;
            inner_en      <= 1'b0;
            outer_en      <= 1'b0;
            filling       <= 1'b0;
            draining      <= 1'b0;
            waiting       <= 1'b0;
            pressure_high <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            state_leds    <= 4'd0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            rec_reg   <= rec_next;
            if (timed_next && state_next == state_reg)
                timer_reg <= timer_reg + CNT_ONE;
            else
                timer_reg <= '0;
            // Pressure survives a fault so recovery knows it must drain first.
            if (state_next == S_FILL)
                pressure_high <= 1'b1;
            else if (state_reg == S_DRAIN && state_next != S_DRAIN && state_next != S_FAULT)
                pressure_high <= 1'b0;
            inner_en   <= (state_next == S_IN_REL)  || (state_next == S_IN_USE);
            outer_en   <= (state_next == S_OUT_REL) || (state_next == S_OUT_USE);
            filling    <= (state_next == S_FILL);
            draining   <= (state_next == S_DRAIN);
            waiting    <= (state_next == S_HOLD);
            busy       <= (state_next != S_IDLE);
            fault      <= (state_next == S_FAULT);
            state_leds <= state_next;
        end
    end

endmodule

// File: tb/tb_airlock_seq_ctrl.sv
// Directed bench for airlock_seq_ctrl with short timers (WAIT=4, FILL=3, DRAIN=3).
// Outputs are checked as a packed word {inner_en,outer_en,filling,draining,waiting,pressure_high,busy,fault,state_leds}.
module tb_airlock_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       inner_sw = 1'b0;
    logic       outer_sw = 1'b0;
    logic       occupied = 1'b0;
    logic       fault_clr = 1'b0;
    logic       inner_en, outer_en, filling, draining, waiting;
    logic       pressure_high, busy, fault;
    logic [3:0] state_leds;

    int n_cmp = 0;
    int n_bad = 0;

    airlock_seq_ctrl #(
        .CNT_W(8), .WAIT_CYC(4), .FILL_CYC(3), .DRAIN_CYC(3)
    ) dut (
        .clk(clk), .reset(reset),
        .arrive_req(arrive_req), .depart_req(depart_req),
        .inner_sw(inner_sw), .outer_sw(outer_sw),
        .occupied(occupied), .fault_clr(fault_clr),
        .inner_en(inner_en), .outer_en(outer_en),
        .filling(filling), .draining(draining), .waiting(waiting),
        .pressure_high(pressure_high), .busy(busy), .fault(fault),
        .state_leds(state_leds)
    );

    always #5 clk = ~clk;

    // Flag order: ie oe fi dr wa ph bu fa
    localparam logic [7:0] F_IDLE   = 8'b0000_0000;
    localparam logic [7:0] F_HOLD   = 8'b0000_1010;
    localparam logic [7:0] F_FILL   = 8'b0010_0110;
    localparam logic [7:0] F_DRAIN  = 8'b0001_0110;
    localparam logic [7:0] F_INLO   = 8'b1000_0010;
    localparam logic [7:0] F_OUTHI  = 8'b0100_0110;
    localparam logic [7:0] F_FLTHI  = 8'b0000_0111;

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end else begin
            $display("ok   %s: %03h", tag, got);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] leds, input logic [7:0] flags);
        check_val(tag,
                  {inner_en, outer_en, filling, draining, waiting, pressure_high, busy, fault, state_leds},
                  {flags, leds});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arrive();
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
    endtask

    initial begin
        tick(2);
        expect_out("reset_state", 4'd0, F_IDLE);
        reset = 1'b0;
        tick();

        // 1: full arrive cycle
        pulse_arrive();
        expect_out("t1_hold_first", 4'd1, F_HOLD);
        tick(3);
        expect_out("t1_hold_last", 4'd1, F_HOLD);
        tick();
        expect_out("t1_fill_first", 4'd2, F_FILL);
        tick(2);
        expect_out("t1_fill_last", 4'd2, F_FILL);
        tick();
        expect_out("t1_out_rel", 4'd6, F_OUTHI);
        outer_sw = 1'b1;
        tick();
        expect_out("t1_out_use", 4'd7, F_OUTHI);
        tick();
        outer_sw = 1'b0;
        tick();
        expect_out("t1_drain_first", 4'd3, F_DRAIN);
        tick(2);
        expect_out("t1_drain_last", 4'd3, F_DRAIN);
        tick();
        expect_out("t1_in_rel", 4'd4, F_INLO);
        inner_sw = 1'b1;
        tick();
        expect_out("t1_in_use", 4'd5, F_INLO);
        inner_sw = 1'b0;
        tick();
        expect_out("t1_idle", 4'd0, F_IDLE);

        // 2: depart cycle with an occupant turning back at the outer door
        occupied   = 1'b1;
        depart_req = 1'b1;
        tick();
        depart_req = 1'b0;
        expect_out("t2_hold", 4'd1, F_HOLD);
        tick(4);
        expect_out("t2_in_rel", 4'd4, F_INLO);
        inner_sw = 1'b1;
        tick();
        inner_sw = 1'b0;
        tick();
        expect_out("t2_fill", 4'd2, F_FILL);
        tick(3);
        expect_out("t2_out_rel", 4'd6, F_OUTHI);
        outer_sw = 1'b1;
        tick();
        outer_sw = 1'b0;
        tick();
        expect_out("t2_back_out_rel", 4'd6, F_OUTHI);
        occupied = 1'b0;
        outer_sw = 1'b1;
        tick();
        outer_sw = 1'b0;
        tick();
        expect_out("t2_drain", 4'd3, F_DRAIN);
        tick(3);
        expect_out("t2_idle", 4'd0, F_IDLE);

        // 3: simultaneous requests resolve to arrive; request during FILL ignored
        arrive_req = 1'b1;
        depart_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        depart_req = 1'b0;
        tick(4);
        expect_out("t3_arr_wins_fill", 4'd2, F_FILL);
        depart_req = 1'b1;
        tick();
        depart_req = 1'b0;
        expect_out("t3_req_ignored", 4'd2, F_FILL);

        // 4: inner door opened during FILL cycle 2
        inner_sw = 1'b1;
        tick();
        expect_out("t4_fault", 4'd15, F_FLTHI);
        fault_clr = 1'b1;
        tick();
        expect_out("t4_clr_blocked", 4'd15, F_FLTHI);
        inner_sw = 1'b0;
        tick();
        fault_clr = 1'b0;
        expect_out("t4_recover_drain", 4'd3, F_DRAIN);
        tick(2);
        expect_out("t4_drain_last", 4'd3, F_DRAIN);
        tick();
        expect_out("t4_idle", 4'd0, F_IDLE);

        // 5: both doors open in OUT_USE; recovery drain returns to IDLE despite arrive direction
        pulse_arrive();
        tick(7);
        expect_out("t5_out_rel", 4'd6, F_OUTHI);
        outer_sw = 1'b1;
        tick();
        expect_out("t5_out_use", 4'd7, F_OUTHI);
        inner_sw = 1'b1;
        tick();
        expect_out("t5_fault", 4'd15, F_FLTHI);
        inner_sw  = 1'b0;
        outer_sw  = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        expect_out("t5_recover_drain", 4'd3, F_DRAIN);
        tick(3);
        expect_out("t5_idle", 4'd0, F_IDLE);

        // 6: asynchronous reset in the middle of DRAIN
        pulse_arrive();
        tick(7);
        outer_sw = 1'b1;
        tick();
        outer_sw = 1'b0;
        tick(2);
        expect_out("t6_mid_drain", 4'd3, F_DRAIN);
        #2;
        reset = 1'b1;
        #1;
        expect_out("t6_async_reset", 4'd0, F_IDLE);
        tick();
        reset = 1'b0;
        tick();
        pulse_arrive();
        expect_out("t6_after_reset_hold", 4'd1, F_HOLD);
        tick(4);
        expect_out("t6_after_reset_fill", 4'd2, F_FILL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
